// File: rtl/flash_page_writer_pkg.sv
// Shared definitions for the flash page writer.
// Holds the SPI flash opcodes, the sequencer state encoding, the WIP bit
// position, the page size, and the job request legality check.
package flash_page_writer_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'hD8;

    localparam int WIP_BIT    = 0;
    localparam int PAGE_BYTES = 256;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL,
        ST_WREN,
        ST_SE,
        ST_SE_POLL,
        ST_WREN2,
        ST_PP,
        ST_PP_POLL,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    // A job is legal when it has 1..256 bytes and stays inside one page.
    function automatic logic start_ok(input logic [23:0] addr, input logic [8:0] len);
        logic [9:0] end_off;
        end_off = {2'b00, addr[7:0]} + {1'b0, len};
        return (len != 9'd0) && (len <= 9'(PAGE_BYTES)) && (end_off <= 10'(PAGE_BYTES));
    endfunction

endpackage

// File: rtl/flash_page_writer_buf.sv
// flash_page_buf: one-page byte buffer (256 x 8 simple dual-port RAM).
// Ports:
//   clk, rst         clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data   synchronous write port
//   rd_en/rd_addr    read port; rd_data is registered (1-cycle latency)
//   rd_data          last read byte, 0 after reset
module flash_page_buf
    import flash_page_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [0:PAGE_BYTES-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register only updates when enabled so it keeps its reset value
    // until the page program phase and never exposes uninitialised RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= 8'h00;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/flash_page_writer.sv
// flash_page_writer: sequences one page-program job onto the SPI flash
// command engine: buffer the job bytes, then WREN -> [SE -> RDSR poll ->
// WREN] -> PP -> RDSR poll, one command at a time.
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_wr_start/addr/len/erase    job request (ignored while busy)
//   i_wr_data/i_wr_data_valid    job byte stream, accepted in FILL only
//   o_busy/o_done/o_err/o_status job status; o_status = last RDSR byte
//   o_cmd/o_cmd_valid/o_addr/o_byte_size/i_cmd_ack   command handshake
//   i_data_req/o_data_in         PP byte supply to the engine
//   i_data_out/i_data_valid      bytes read back by the engine (RDSR)
module flash_page_writer
    import flash_page_writer_pkg::*;
#(
    parameter logic [15:0] POLL_MAX = 16'd65535,
    parameter logic [15:0] POLL_GAP = 16'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_start,
    input  logic [23:0] i_wr_addr,
    input  logic [8:0]  i_wr_len,
    input  logic        i_erase,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_data_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_status,
    output logic [7:0]  o_cmd,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ack,
    output logic [23:0] o_addr,
    output logic [8:0]  o_byte_size,
    input  logic        i_data_req,
    output logic [7:0]  o_data_in,
    input  logic [7:0]  i_data_out,
    input  logic        i_data_valid
);

    state_t      state;
    state_t      ret_state;   // poll state to resume after GAP
    logic        issued;      // command of the current state already pulsed
    logic [23:0] addr_q;
    logic [8:0]  len_q;
    logic        erase_q;
    logic [8:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic [15:0] poll_cnt;
    logic [15:0] gap_cnt;

    logic [7:0]  iss_cmd;
    logic [23:0] iss_addr;
    logic [8:0]  iss_size;
    logic        cur_wip;
    logic        poll_timeout;
    logic        gap_over;

    flash_page_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (state == ST_FILL && i_wr_data_valid),
        .wr_addr (wr_ptr[7:0]),
        .wr_data (i_wr_data),
        .rd_en   (state == ST_PP),
        .rd_addr (rd_ptr),
        .rd_data (o_data_in)
    );

    // Status may arrive in the same cycle as the ack; use it directly then.
    assign cur_wip      = i_data_valid ? i_data_out[WIP_BIT] : o_status[WIP_BIT];
    assign poll_timeout = ({1'b0, poll_cnt} + 17'd1) == {1'b0, POLL_MAX};
    assign gap_over     = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, POLL_GAP};

    always_comb begin
        iss_cmd  = OP_WREN;
        iss_addr = '0;
        iss_size = '0;
        case (state)
            ST_SE: begin
                iss_cmd  = OP_SE;
                iss_addr = {addr_q[23:16], 16'h0000};
            end
            ST_SE_POLL, ST_PP_POLL: iss_cmd = OP_RDSR;
            ST_PP: begin
                iss_cmd  = OP_PP;
                iss_addr = addr_q;
                iss_size = len_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ret_state   <= ST_IDLE;
            issued      <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            erase_q     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            poll_cnt    <= '0;
            gap_cnt     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_status    <= 8'h00;
            o_cmd       <= 8'h00;
            o_cmd_valid <= 1'b0;
            o_addr      <= '0;
            o_byte_size <= '0;
        end else begin
            o_cmd_valid <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;

            if ((state == ST_SE_POLL || state == ST_PP_POLL) && i_data_valid)
                o_status <= i_data_out;

            case (state)
                ST_IDLE: begin
                    if (i_wr_start) begin
                        if (start_ok(i_wr_addr, i_wr_len)) begin
                            addr_q  <= i_wr_addr;
                            len_q   <= i_wr_len;
                            erase_q <= i_erase;
                            wr_ptr  <= '0;
                            o_busy  <= 1'b1;
                            state   <= ST_FILL;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end

                ST_FILL: begin
                    if (i_wr_data_valid) begin
                        wr_ptr <= wr_ptr + 9'd1;
                        if (wr_ptr + 9'd1 == len_q) begin
                            issued <= 1'b0;
                            state  <= erase_q ? ST_WREN : ST_WREN2;
                        end
                    end
                end

                ST_WREN, ST_SE, ST_SE_POLL, ST_WREN2, ST_PP, ST_PP_POLL: begin
                    // Byte pointer advances independently of the handshake.
                    if (state == ST_PP && i_data_req && ({1'b0, rd_ptr} != len_q - 9'd1))
                        rd_ptr <= rd_ptr + 8'd1;

                    if (!issued) begin
                        o_cmd       <= iss_cmd;
                        o_addr      <= iss_addr;
                        o_byte_size <= iss_size;
                        o_cmd_valid <= 1'b1;
                        issued      <= 1'b1;
                    end else if (i_cmd_ack) begin
                        issued <= 1'b0;
                        case (state)
                            ST_WREN: state <= ST_SE;
                            ST_SE: begin
                                poll_cnt <= '0;
                                state    <= ST_SE_POLL;
                            end
                            ST_WREN2: begin
                                rd_ptr <= '0;
                                state  <= ST_PP;
                            end
                            ST_PP: begin
                                poll_cnt <= '0;
                                state    <= ST_PP_POLL;
                            end
                            default: begin  // SE_POLL / PP_POLL
                                if (!cur_wip) begin
                                    state <= (state == ST_SE_POLL) ? ST_WREN2 : ST_DONE;
                                end else begin
                                    poll_cnt <= poll_cnt + 16'd1;
                                    if (poll_timeout) begin
                                        state <= ST_ERR;
                                    end else begin
                                        ret_state <= state;
                                        gap_cnt   <= '0;
                                        state     <= ST_GAP;
                                    end
                                end
                            end
                        endcase
                    end
                end

                ST_GAP: begin
                    if (gap_over) begin
                        issued <= 1'b0;
                        state  <= ret_state;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                ST_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end

                ST_ERR: begin
                    o_err  <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_page_writer.sv
// Scoreboard bench for flash_page_writer: a job model pushes expected
// commands, bytes and outcomes; a monitor and a responding engine model
// pop and compare.
module tb_flash_page_writer;

    localparam logic [15:0] PMAX = 16'd3;
    localparam logic [15:0] PGAP = 16'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wr_start, i_erase, i_wr_data_valid;
    logic [23:0] i_wr_addr;
    logic [8:0]  i_wr_len;
    logic [7:0]  i_wr_data;
    logic        o_busy, o_done, o_err, o_cmd_valid;
    logic [7:0]  o_status, o_cmd, o_data_in;
    logic        i_cmd_ack, i_data_req, i_data_valid;
    logic [23:0] o_addr;
    logic [8:0]  o_byte_size;
    logic [7:0]  i_data_out;

    flash_page_writer #(.POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
        .clk(clk), .rst(rst),
        .i_wr_start(i_wr_start), .i_wr_addr(i_wr_addr), .i_wr_len(i_wr_len),
        .i_erase(i_erase), .i_wr_data(i_wr_data), .i_wr_data_valid(i_wr_data_valid),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_status(o_status),
        .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid), .i_cmd_ack(i_cmd_ack),
        .o_addr(o_addr), .o_byte_size(o_byte_size), .i_data_req(i_data_req),
        .o_data_in(o_data_in), .i_data_out(i_data_out), .i_data_valid(i_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [8:0]  size;
    } cmd_t;

    cmd_t       exp_cmd[$];
    int         exp_evt[$];     // 0 = done, 1 = err
    logic [7:0] exp_bytes[$];
    logic [7:0] stat_q[$];      // statuses the engine returns, in order
    logic [7:0] scr[$];         // status script for the next job

    int total = 0;
    int bad   = 0;

    // engine model state, visible to the stimulus for the reset test
    bit         e_busy = 0;
    logic [7:0] e_op   = 8'h00;
    int         e_left = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [23:0] a, input logic [8:0] sz);
        cmd_t c;
        c.op = op; c.addr = a; c.size = sz;
        exp_cmd.push_back(c);
    endtask

    // Reference for one busy-wait: each read consumes a script entry
    // (missing entries read as 00h); stop on WIP clear or after PMAX busy reads.
    task automatic poll_model(inout int k, inout bit fail, inout logic [7:0] last_st);
        logic [7:0] st;
        for (int n = 0; n < 100000; n++) begin
            push_cmd(8'h05, 24'h0, 9'h0);
            st = (k < scr.size()) ? scr[k] : 8'h00;
            k++;
            last_st = st;
            if (!st[0]) break;
            if (n + 1 == int'(PMAX)) begin
                fail = 1;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_err"},   o_err, 0);
        chk({tag, "_cmdv"},  o_cmd_valid, 0);
        chk({tag, "_cmd"},   o_cmd, 0);
        chk({tag, "_addr"},  o_addr, 0);
        chk({tag, "_size"},  o_byte_size, 0);
        chk({tag, "_din"},   o_data_in, 0);
        chk({tag, "_stat"},  o_status, 0);
    endtask

    // Issue a job and stream its bytes; builds all expectations from scr.
    task automatic start_and_fill(input logic [23:0] a, input int len, input bit er,
                                  input bit seq, input logic [7:0] base, input bit junk,
                                  output bit is_bad, output logic [7:0] last_st);
        bit fail;
        int k;
        bit pp_reached;
        logic [7:0] b;
        is_bad = (len == 0) || (len > 256) || ((int'(a[7:0]) + len) > 256);
        fail = 0; k = 0; pp_reached = 0; last_st = 8'h00;
        stat_q = scr;
        if (is_bad) begin
            exp_evt.push_back(1);
        end else begin
            if (er) begin
                push_cmd(8'h06, 24'h0, 9'h0);
                push_cmd(8'hD8, {a[23:16], 16'h0000}, 9'h0);
                poll_model(k, fail, last_st);
            end
            if (!fail) begin
                pp_reached = 1;
                push_cmd(8'h06, 24'h0, 9'h0);
                push_cmd(8'h02, a, 9'(len));
                poll_model(k, fail, last_st);
            end
            exp_evt.push_back(fail ? 1 : 0);
        end

        @(negedge clk);
        i_wr_start = 1; i_wr_addr = a; i_wr_len = 9'(len); i_erase = er;
        if (junk) begin i_wr_data_valid = 1; i_wr_data = 8'hEE; end
        @(negedge clk);
        i_wr_start = 0; i_wr_data_valid = 0;
        chk("busy_at_start", o_busy, is_bad ? 0 : 1);
        if (!is_bad) begin
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                b = seq ? base + 8'(i) : 8'($urandom);
                if (pp_reached) exp_bytes.push_back(b);
                i_wr_data_valid = 1; i_wr_data = b;
                @(negedge clk);
                i_wr_data_valid = 0;
            end
        end
    endtask

    task automatic run_job(input logic [23:0] a, input int len, input bit er,
                           input bit seq, input logic [7:0] base, input bit junk);
        bit is_bad;
        logic [7:0] last_st;
        int n;
        start_and_fill(a, len, er, seq, base, junk, is_bad, last_st);
        n = 0;
        while (!(o_done || o_err) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            total++; bad++;
            $display("FAIL job_timeout got=no_done_err required=done_or_err");
        end
        @(negedge clk);
        chk("busy_after_job", o_busy, 0);
        if (!is_bad) chk("final_status", o_status, last_st);
        chk("cmds_left", exp_cmd.size(), 0);
        chk("evts_left", exp_evt.size(), 0);
        chk("bytes_left", exp_bytes.size(), 0);
        exp_bytes.delete();
        repeat (3) @(negedge clk);
    endtask

    // Monitor: command stream, single-cycle valid, RDSR spacing, outcomes.
    initial begin : monitor
        int  cyc = 0;
        int  last_rdsr = 0;
        bit  prev_v = 0;
        bit  last_was_rdsr = 0;
        cmd_t e;
        int  ev;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_v = 0;
                last_was_rdsr = 0;
            end else begin
                if (o_cmd_valid) begin
                    chk("valid_2cyc", prev_v, 0);
                    if (exp_cmd.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_cmd got=%0h required=none", o_cmd);
                    end else begin
                        e = exp_cmd.pop_front();
                        chk("cmd_op", o_cmd, e.op);
                        if (e.op == 8'hD8 || e.op == 8'h02) chk("cmd_addr", o_addr, e.addr);
                        if (e.op == 8'h02) chk("cmd_size", o_byte_size, e.size);
                    end
                    if (o_cmd == 8'h05) begin
                        if (last_was_rdsr) chk("rdsr_gap_ok", (cyc - last_rdsr) > int'(PGAP), 1);
                        last_rdsr = cyc;
                        last_was_rdsr = 1;
                    end else begin
                        last_was_rdsr = 0;
                    end
                end
                prev_v = o_cmd_valid;
                if (o_done || o_err) begin
                    if (exp_evt.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_evt got=done%0d_err%0d required=none", o_done, o_err);
                    end else begin
                        ev = exp_evt.pop_front();
                        chk("evt_err", o_err, ev);
                        chk("evt_done", o_done, ev == 0);
                    end
                    chk("busy_drop_at_evt", o_busy, 0);
                end
            end
        end
    end

    // Engine model: accepts one command at a time and acks after a random
    // latency; returns scripted RDSR status and pulls PP bytes.
    initial begin : engine
        int         ec = 0;
        int         lat = 2;
        bit         sat = 0;
        logic [7:0] lastb = 8'h00;
        logic [7:0] b;
        i_cmd_ack = 0; i_data_req = 0; i_data_valid = 0; i_data_out = 8'h00;
        forever begin
            @(negedge clk);
            i_cmd_ack = 0; i_data_valid = 0; i_data_req = 0;
            if (rst) begin
                e_busy = 0;
            end else if (!e_busy) begin
                if (o_cmd_valid) begin
                    e_busy = 1; e_op = o_cmd; ec = 0; e_left = int'(o_byte_size);
                    sat = 0; lat = $urandom_range(2, 6);
                end
            end else begin
                ec++;
                if (e_op == 8'h05) begin
                    if (ec == lat) begin
                        i_data_valid = 1;
                        i_data_out = (stat_q.size() != 0) ? stat_q.pop_front() : 8'h00;
                    end else if (ec == lat + 1) begin
                        i_cmd_ack = 1;
                    end
                end else if (e_op == 8'h02) begin
                    if (ec % 3 == 0) begin
                        if (e_left > 0) begin
                            if (exp_bytes.size() == 0) begin
                                total++; bad++;
                                $display("FAIL pp_extra_byte got=%0h required=none", o_data_in);
                            end else begin
                                b = exp_bytes.pop_front();
                                chk("pp_byte", o_data_in, b);
                                lastb = b;
                            end
                            i_data_req = 1;
                            e_left--;
                        end else if (!sat) begin
                            chk("pp_sat_byte", o_data_in, lastb);
                            sat = 1;
                        end else begin
                            i_cmd_ack = 1;
                        end
                    end
                end else if (ec == lat) begin
                    i_cmd_ack = 1;
                end
                if (i_cmd_ack) begin
                    chk("cmd_hold", o_cmd, e_op);
                    e_busy = 0;
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] r;
        int          len;
        int          off;
        bit          is_bad;
        logic [7:0]  last_st;
        int          n;
        rst = 1;
        i_wr_start = 0; i_wr_addr = '0; i_wr_len = '0; i_erase = 0;
        i_wr_data = '0; i_wr_data_valid = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        #2 rst = 0;

        // page write, no erase, start with a same-cycle byte that must be dropped
        scr = '{8'h00};
        run_job(24'h012300, 4, 0, 1, 8'hA1, 1);
        // erase + two busy polls after SE
        scr = '{8'h01, 8'h01, 8'h00, 8'h00};
        run_job(24'h0540F0, 16, 1, 0, 8'h00, 0);
        // rejects: page crossing, zero length, over-length
        scr = '{};
        run_job(24'h0000F8, 16, 0, 0, 8'h00, 0);
        run_job(24'h001200, 0, 0, 0, 8'h00, 0);
        run_job(24'h001200, 257, 0, 0, 8'h00, 0);
        // boundaries that are legal
        scr = '{8'h00};
        run_job(24'h0033FF, 1, 0, 0, 8'h00, 0);
        scr = '{8'h40};
        run_job(24'h7F1000, 256, 0, 0, 8'h00, 0);
        // stuck WIP after PP: timeout after PMAX reads
        scr = '{8'h01, 8'h01, 8'h01};
        run_job(24'h002010, 8, 0, 0, 8'h00, 0);
        // stuck WIP after SE: PP never issued
        scr = '{8'h03, 8'h01, 8'h81};
        run_job(24'h0A0000, 5, 1, 0, 8'h00, 0);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            r = $urandom;
            len = $urandom_range(1, 256);
            off = $urandom_range(0, 256 - len);
            if ($urandom_range(0, 5) == 0) off = 256 - len + $urandom_range(1, 8);
            scr.delete();
            for (int s = 0; s < 8; s++) begin
                r[31:24] = 8'($urandom);
                r[24] = ($urandom_range(0, 2) == 0);
                scr.push_back(r[31:24]);
            end
            run_job({r[23:8], 8'(off)}, len, r[0], 0, 8'h00, r[1]);
        end

        // reset in the middle of the PP data phase
        scr = '{8'h00};
        start_and_fill(24'h003300, 64, 0, 0, 8'h00, 0, is_bad, last_st);
        n = 0;
        while (!(e_busy && e_op == 8'h02 && e_left < 60) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_pp_phase", n < 5000, 1);
        #2 rst = 1;
        #1 check_reset_vals("midrst");
        repeat (2) @(negedge clk);
        exp_cmd.delete(); exp_evt.delete(); exp_bytes.delete(); stat_q.delete();
        #2 rst = 0;
        scr = '{8'h01, 8'h00, 8'h00};
        run_job(24'h0400C0, 32, 1, 1, 8'h10, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
